muldiv_ctrl: RTL and testbench

Multicycle sequencer for the MULT/DIV instructions of the processor datapath. The main control unit hands it two register operands and an opcode, then stalls on `busy` until `done`. The block iterates a 32-step shift/add (multiply) or restoring subtract (divide) engine and writes the 64-bit result into its internal HI/LO registers, which feed the MFHI/MFLO path. A zero divisor is detected at issue and flagged without iterating.

---
 rtl/muldiv_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multicycle sequencer for MULT/DIV with HI/LO result registers.
// A 32-step shift/add multiply or restoring divide runs on operand magnitudes.
// A single FIXUP cycle then applies the result signs.
// Optional build macro: MULDIV_UNSIGNED_EN. When defined, op[1] = 1 selects MULTU/DIVU.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Two's-complement negation helpers, shared by magnitude and fixup logic
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_r, state_next_s;
    logic [WIDTH-1:0]     opa_r, opb_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;
    logic                 is_div_r, neg_res_r, neg_rem_r;
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 busy_r, done_r, div_zero_r;

    logic                 signed_mode_s, sign_a_s, sign_b_s, dz_issue_s;
    logic [WIDTH-1:0]     mag_a_s, mag_b_s;
    logic [WIDTH:0]       mul_sum_s, div_shift_s;
    logic [WIDTH+1:0]     div_diff_s;
    logic [2*WIDTH-1:0]   acc_step_s, prod_s;
    logic [WIDTH-1:0]     quot_s, rem_s, fix_hi_s, fix_lo_s;

`ifdef MULDIV_UNSIGNED_EN
    assign signed_mode_s = ~op[1];
`else
    logic unused_op_s;
    assign signed_mode_s = 1'b1;
    assign unused_op_s   = op[1];
`endif

    // Issue decode: operand signs, magnitudes and the divide-by-zero shortcut
    always_comb begin
        sign_a_s   = signed_mode_s & src_a[WIDTH-1];
        sign_b_s   = signed_mode_s & src_b[WIDTH-1];
        mag_a_s    = sign_a_s ? neg_w(src_a) : src_a;
        mag_b_s    = sign_b_s ? neg_w(src_b) : src_b;
        dz_issue_s = (state_r == ST_IDLE) && start && op[0] && (src_b == {WIDTH{1'b0}});
    end

    // One iteration step: shift/add for multiply, shift/trial-subtract for divide
    always_comb begin
        acc_step_s  = acc_r;
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (opb_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], opa_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opb_r};
        if (is_div_r) begin
            if (div_diff_s[WIDTH+1]) begin
                acc_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end else begin
                acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign fixup of the finished magnitude result into HI/LO values
    always_comb begin
        prod_s = neg_res_r ? neg_2w(acc_r) : acc_r;
        quot_s = neg_res_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        rem_s  = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        if (is_div_r) begin
            fix_hi_s = rem_s;
            fix_lo_s = quot_s;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Next-state logic of the sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dz_issue_s) begin
                    state_next_s = ST_DONE;
                end else if (start) begin
                    state_next_s = ST_ITER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = ST_FIXUP;
                end else begin
                    state_next_s = ST_ITER;
                end
            end
            ST_FIXUP: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch, iteration datapath and HI/LO result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            opa_r     <= {WIDTH{1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CW{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !dz_issue_s) begin
                        opa_r     <= mag_a_s;
                        opb_r     <= mag_b_s;
                        acc_r     <= {(2*WIDTH){1'b0}};
                        cnt_r     <= LAST_STEP;
                        is_div_r  <= op[0];
                        neg_res_r <= sign_a_s ^ sign_b_s;
                        neg_rem_r <= sign_a_s;
                    end
                end
                ST_ITER: begin
                    acc_r <= acc_step_s;
                    if (is_div_r) begin
                        opa_r <= {opa_r[WIDTH-2:0], 1'b0};
                    end else begin
                        opb_r <= {1'b0, opb_r[WIDTH-1:1]};
                    end
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_FIXUP: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                ST_DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Registered status outputs, decoded from the upcoming state
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            busy_r     <= (state_next_s != ST_IDLE);
            done_r     <= (state_next_s == ST_DONE);
            div_zero_r <= dz_issue_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl.
// Outputs are sampled on the falling clock edge.
module tb_muldiv_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Drive one issue; returns at the falling edge after the issue edge (cycle 0)
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clock);
        start = 1'b0; op = 2'b01; src_a = 32'hDEADBEEF; src_b = 32'h0BADF00D;
    endtask

    // Wait (bounded) for done; c counts cycles since the issue edge
    task automatic wait_done(output int c, output bit seen);
        c = 0; seen = 1'b0;
        while (c < 60 && !seen) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clock);
                c++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'h0; src_b = 32'h0;
        repeat (2) @(negedge clock);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b exp 0", div_zero); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", lo); end
        reset = 1'b1;
    endtask

    task automatic test_mult;
        int c; bit seen;
        issue(2'b00, 32'd7, 32'hFFFFFFFD);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_start got %b exp 1", busy); end
        wait_done(c, seen);
        n_tests++; if (!seen || c != 33) begin n_fail++; $display("FAIL mult_latency got %0d (seen %b) exp 33", c, seen); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h exp FFFFFFFF", hi); end
        n_tests++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo got %h exp FFFFFFEB", lo); end
        n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL mult_dz got %b exp 0", div_zero); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_done got %b exp 1", busy); end
        @(negedge clock);
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mult_after got busy %b done %b exp 0 0", busy, done); end
    endtask

    task automatic test_div;
        int c; bit seen;
        issue(2'b01, 32'hFFFFFFF9, 32'd2);
        wait_done(c, seen);
        n_tests++; if (!seen || c != 33) begin n_fail++; $display("FAIL div_latency got %0d exp 33", c); end
        n_tests++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h exp FFFFFFFD", lo); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h exp FFFFFFFF", hi); end
        issue(2'b01, 32'h80000000, 32'hFFFFFFFF);
        wait_done(c, seen);
        n_tests++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo got %h exp 80000000", lo); end
        n_tests++; if (hi !== 32'h0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL divovf_hi got %h dz %b exp 0 0", hi, div_zero); end
        issue(2'b01, 32'd100, 32'hFFFFFFF9);
        wait_done(c, seen);
        n_tests++; if (lo !== 32'hFFFFFFF2 || hi !== 32'd2) begin n_fail++; $display("FAIL div100_m7 got hi %h lo %h exp 00000002 FFFFFFF2", hi, lo); end
    endtask

    task automatic test_div_zero;
        int c; bit seen;
        issue(2'b00, 32'h00012345, 32'h00000010);
        wait_done(c, seen);
        n_tests++; if (lo !== 32'h00123450 || hi !== 32'h0) begin n_fail++; $display("FAIL preload got hi %h lo %h exp 0 00123450", hi, lo); end
        @(negedge clock);
        issue(2'b01, 32'd5, 32'd0);
        n_tests++; if (done !== 1'b1 || div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_pulse got done %b dz %b exp 1 1", done, div_zero); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dz_busy got %b exp 1", busy); end
        @(negedge clock);
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_after got busy %b done %b dz %b exp 0 0 0", busy, done, div_zero); end
        n_tests++; if (lo !== 32'h00123450 || hi !== 32'h0) begin n_fail++; $display("FAIL dz_hold got hi %h lo %h exp 0 00123450", hi, lo); end
    endtask

    task automatic test_start_ignored;
        int n_done = 0; int c_at = -1;
        issue(2'b00, 32'd3, 32'd4);
        for (int c = 0; c < 45; c++) begin
            if (done === 1'b1) begin n_done++; c_at = c; end
            if (c == 5) begin start = 1'b1; op = 2'b01; src_a = 32'd100; src_b = 32'd7; end
            if (c == 6) start = 1'b0;
            @(negedge clock);
        end
        n_tests++; if (n_done != 1 || c_at != 33) begin n_fail++; $display("FAIL ignore_start got %0d dones at %0d exp 1 at 33", n_done, c_at); end
        n_tests++; if (lo !== 32'd12 || hi !== 32'd0) begin n_fail++; $display("FAIL ignore_result got hi %h lo %h exp 0 0000000C", hi, lo); end
    endtask

    task automatic test_reset_abort;
        int n_done = 0;
        issue(2'b00, 32'd9, 32'd9);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_busy got busy %b done %b exp 0 0", busy, done); end
        n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL abort_hilo got hi %h lo %h exp 0 0", hi, lo); end
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done === 1'b1) n_done++;
        end
        n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL abort_nodone got %0d exp 0", n_done); end
    endtask

    task automatic test_unsigned;
        int c; bit seen;
        logic [31:0] exp_hi;
`ifdef MULDIV_UNSIGNED_EN
        exp_hi = 32'h00000001;
`else
        exp_hi = 32'hFFFFFFFF;
`endif
        issue(2'b10, 32'hFFFFFFFF, 32'd2);
        wait_done(c, seen);
        n_tests++; if (!seen || c != 33) begin n_fail++; $display("FAIL uns_latency got %0d exp 33", c); end
        n_tests++; if (hi !== exp_hi || lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL uns_mult got hi %h lo %h exp %h FFFFFFFE", hi, lo, exp_hi); end
    endtask

    task automatic test_back_to_back;
        int c; bit seen; int t1; int t2;
        @(negedge clock);
        start = 1'b1; op = 2'b00; src_a = 32'd6; src_b = 32'd7;
        @(negedge clock);
        wait_done(c, seen);
        t1 = cyc;
        n_tests++; if (!seen || lo !== 32'd42) begin n_fail++; $display("FAIL b2b_first got seen %b lo %h exp 1 0000002A", seen, lo); end
        @(negedge clock);
        src_a = 32'd5; src_b = 32'd11;
        @(negedge clock);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_reissue got busy %b exp 1", busy); end
        start = 1'b0;
        wait_done(c, seen);
        t2 = cyc;
        n_tests++; if (!seen || (t2 - t1) != 35) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 35", t2 - t1); end
        n_tests++; if (lo !== 32'd55 || hi !== 32'd0) begin n_fail++; $display("FAIL b2b_second got hi %h lo %h exp 0 00000037", hi, lo); end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_start_ignored;
        test_reset_abort;
        test_unsigned;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
